// File: rtl/mdu.sv
// Multiply/divide unit holding the HI/LO pair. MULT/DIV run for a fixed
// number of busy cycles and commit atomically; MTHI/MTLO write immediately.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [2:0]         r_op;
  logic [31:0]        w_a_next;
  logic [31:0]        w_b_next;
  logic [2:0]         w_op_next;
  logic               r_busy;
  logic               w_busy_next;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        w_hi_next;
  logic [31:0]        w_lo_next;

  logic [63:0]        w_smul;
  logic [63:0]        w_umul;
  logic               w_div_ovf;
  logic [31:0]        w_sdiv_b;
  logic [31:0]        w_udiv_b;
  logic [31:0]        w_squo;
  logic [31:0]        w_srem;
  logic [31:0]        w_uquo;
  logic [31:0]        w_urem;
  logic               w_res_wr;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;
  logic               w_last;

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

  assign w_smul = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_umul = {32'd0, r_a} * {32'd0, r_b};

  // Divisors are forced to 1 when the result is special-cased, so the divider never sees /0 or overflow.
  assign w_div_ovf = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
  assign w_sdiv_b  = ((r_b == 32'd0) || w_div_ovf) ? 32'd1 : r_b;
  assign w_udiv_b  = (r_b == 32'd0) ? 32'd1 : r_b;
  assign w_squo    = $signed(r_a) / $signed(w_sdiv_b);
  assign w_srem    = $signed(r_a) % $signed(w_sdiv_b);
  assign w_uquo    = r_a / w_udiv_b;
  assign w_urem    = r_a % w_udiv_b;

  assign w_last = (r_cnt == CNT_W'(1));

  // Result selection for the operation in flight.
  always_comb begin
    w_res_wr = 1'b0;
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (r_op)
      OP_MULT: begin
        w_res_wr = 1'b1;
        w_res_hi = w_smul[63:32];
        w_res_lo = w_smul[31:0];
      end
      OP_MULTU: begin
        w_res_wr = 1'b1;
        w_res_hi = w_umul[63:32];
        w_res_lo = w_umul[31:0];
      end
      OP_DIV: begin
        if (r_b == 32'd0) begin
          w_res_wr = 1'b0;
        end else if (w_div_ovf) begin
          w_res_wr = 1'b1;
          w_res_hi = 32'd0;
          w_res_lo = 32'h8000_0000;
        end else begin
          w_res_wr = 1'b1;
          w_res_hi = w_srem;
          w_res_lo = w_squo;
        end
      end
      OP_DIVU: begin
        if (r_b == 32'd0) begin
          w_res_wr = 1'b0;
        end else begin
          w_res_wr = 1'b1;
          w_res_hi = w_urem;
          w_res_lo = w_uquo;
        end
      end
      default: begin
        w_res_wr = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && (op <= OP_DIVU)) begin
          w_state_next = S_BUSY;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_BUSY;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath next values: operand capture, countdown, HI/LO updates.
  always_comb begin
    w_a_next    = r_a;
    w_b_next    = r_b;
    w_op_next   = r_op;
    w_cnt_next  = r_cnt;
    w_hi_next   = r_hi;
    w_lo_next   = r_lo;
    w_busy_next = (w_state_next == S_BUSY);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              w_a_next   = A;
              w_b_next   = B;
              w_op_next  = op;
              w_cnt_next = CNT_W'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
              w_a_next   = A;
              w_b_next   = B;
              w_op_next  = op;
              w_cnt_next = CNT_W'(DIV_CYCLES);
            end
            OP_MTHI: begin
              w_hi_next = A;
            end
            OP_MTLO: begin
              w_lo_next = A;
            end
            default: begin
              w_cnt_next = r_cnt;
            end
          endcase
        end else begin
          w_cnt_next = r_cnt;
        end
      end
      S_BUSY: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (w_last && w_res_wr) begin
          w_hi_next = w_res_hi;
          w_lo_next = w_res_lo;
        end else begin
          w_hi_next = r_hi;
        end
      end
      default: begin
        w_cnt_next = {CNT_W{1'b0}};
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a    <= 32'd0;
      r_b    <= 32'd0;
      r_op   <= 3'd0;
      r_cnt  <= {CNT_W{1'b0}};
      r_busy <= 1'b0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
    end else begin
      r_a    <= w_a_next;
      r_b    <= w_b_next;
      r_op   <= w_op_next;
      r_cnt  <= w_cnt_next;
      r_busy <= w_busy_next;
      r_hi   <= w_hi_next;
      r_lo   <= w_lo_next;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus queues expected HI/LO and busy length,
// a monitor checks them when busy falls.
module tb_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t q[$];
  int   n_checks;
  int   n_errors;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.name = nm; e.hi = h; e.lo = l; e.cycles = c;
    q.push_back(e);
  endtask

  // Drive one start; operands are scrambled after the accepting edge.
  task automatic do_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s_timeout: busy still %b expected 0", nm, busy);
  endtask

  // Monitor: busy high-time and committed HI/LO checked when busy falls.
  initial begin
    bit   prev;
    int   bcnt;
    exp_t e;
    prev = 1'b0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = 1'b0;
        bcnt = 0;
      end else if (busy) begin
        prev = 1'b1;
        bcnt++;
      end else if (prev) begin
        prev = 1'b0;
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: hi %h lo %h with empty scoreboard", hi, lo);
        end else begin
          e = q.pop_front();
          chk({e.name, "_cycles"}, 32'(bcnt), 32'(e.cycles));
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
        end
        bcnt = 0;
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    push("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    do_start(3'd0, 32'hFFFF_FFFE, 32'd3);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_idle("mult_neg");

    push("multu", 32'd1, 32'hFFFF_FFFE, 5);
    do_start(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle("multu");

    push("mult_negneg", 32'd0, 32'd12, 5);
    do_start(3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
    wait_idle("mult_negneg");

    push("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    do_start(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_neg");

    push("divu_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    do_start(3'd3, 32'd7, 32'd0);
    wait_idle("divu_zero");

    push("div_negdivisor", 32'd1, 32'hFFFF_FFFD, 10);
    do_start(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_idle("div_negdivisor");

    push("div_ovf", 32'd0, 32'h8000_0000, 10);
    do_start(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf");

    do_start(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    do_start(3'd5, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_lo", lo, 32'hCAFE_F00D);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);

    do_start(3'd6, 32'hDEAD_BEEF, 32'd1);
    chk("nop_hi", hi, 32'h1234_5678);
    chk("nop_lo", lo, 32'hCAFE_F00D);
    chk("nop_busy", {31'd0, busy}, 32'd0);

    push("mult_ignore_second", 32'd0, 32'd4, 5);
    do_start(3'd0, 32'd2, 32'd2);
    do_start(3'd0, 32'd3, 32'd3);
    chk("busy_hold_hi", hi, 32'h1234_5678);
    do_start(3'd4, 32'h5555_5555, 32'd0);
    chk("mthi_in_busy_ignored", hi, 32'h1234_5678);
    wait_idle("mult_ignore_second");

    do_start(3'd2, 32'd100, 32'd3);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    push("multu_after_reset", 32'd0, 32'd25, 5);
    do_start(3'd1, 32'd5, 32'd5);
    wait_idle("multu_after_reset");

    push("b2b_mult", 32'd0, 32'd42, 5);
    do_start(3'd0, 32'd6, 32'd7);
    begin
      bit seen_low;
      seen_low = 1'b0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        if (!busy) begin
          seen_low = 1'b1;
          break;
        end
      end
      if (!seen_low) begin
        n_checks++;
        n_errors++;
        $display("FAIL b2b_timeout: busy still %b expected 0", busy);
      end
    end
    push("b2b_divu", 32'd2, 32'd14, 10);
    start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0; A = $urandom; B = $urandom;
    chk("b2b_no_gap", {31'd0, busy}, 32'd1);
    wait_idle("b2b_divu");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
